// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer with a single registered output stage.
// Grants by round-robin (rr_en=1) or lowest-index priority; valid/ready on both sides.
module rr_arb_mux #(
  parameter  int N     = 32,
  parameter  int WIDTH = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rr_en,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] idx;
  logic [SEL_W:0]   idx_w;
  logic             found;
  logic             load;
  logic             grant;
  logic [WIDTH-1:0] sel_data;

  assign start = rr_en ? ptr : '0;
  assign load  = !out_valid || out_ready;
  assign grant = found && load && !reset;

  // Walk channels from start with wrap-around; one extra bit keeps the sum from overflowing.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, start} + (SEL_W+1)'(k);
      if (idx_w >= (SEL_W+1)'(N)) idx_w = idx_w - (SEL_W+1)'(N);
      idx = idx_w[SEL_W-1:0];
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SEL_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = grant;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (grant) begin
      out_data  <= sel_data;
      out_sel   <= win;
      out_valid <= 1'b1;
      if (rr_en) ptr <= (win == SEL_W'(N-1)) ? '0 : win + SEL_W'(1);
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed + randomized bench for rr_arb_mux (N=4, WIDTH=8) with an
// independent reference model and an output scoreboard queue.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           rr_en;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  rr_arb_mux #(.N(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .rr_en     (rr_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic       m_valid;
  logic [1:0] m_sel;
  logic [W-1:0] m_data;
  int         m_ptr;
  logic [9:0] sb_q[$];   // {sel, data}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_win(input logic [N-1:0] v, input logic rr, input int p);
    int c;
    for (int k = 0; k < N; k++) begin
      c = rr ? (p + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] d, input int c);
    logic [N*W-1:0] t;
    t = d >> (c * W);
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = '0;
    m_data  = '0;
    m_ptr   = 0;
    sb_q.delete();
  endtask

  // One clock: check grant against model, push expectation, clock, pop and compare outputs.
  task automatic step(input string tag);
    int         w;
    bit         ld;
    bit         xfer;
    logic [N-1:0] exp_rdy;
    logic [9:0] e;
    #1;
    ld      = !m_valid || out_ready;
    w       = model_win(in_valid, rr_en, m_ptr);
    xfer    = ld && (w >= 0);
    exp_rdy = xfer ? N'(1 << w) : '0;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (xfer) sb_q.push_back({2'(w), chan_data(in_data, w)});
    @(posedge clock);
    #1;
    if (xfer) begin
      e       = sb_q.pop_front();
      m_valid = 1'b1;
      m_sel   = e[9:8];
      m_data  = e[7:0];
      if (rr_en) m_ptr = (w == N-1) ? 0 : w + 1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data));
  endtask

  initial begin
    reset     = 1'b1;
    rr_en     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'hA0 + i);
    model_reset();
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);
    check("rst.out_sel",   32'(out_sel),   32'd0);
    in_valid = 4'b1111;
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    in_valid = '0;
    @(negedge clock);
    reset = 1'b0;

    // round-robin fairness: 0,1,2,3,0,1,2,3
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step("rr_fair");
      check("rr_fair.seq", 32'(out_sel), 32'(i % N));
    end

    // fixed priority
    rr_en    = 1'b0;
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step("fixed");
      check("fixed.sel1", 32'(out_sel), 32'd1);
    end
    in_valid = 4'b1000;
    for (int i = 0; i < 2; i++) step("fixed_drop");
    check("fixed.sel3", 32'(out_sel), 32'd3);

    // backpressure: hold 3 cycles, then load on the cycle out_ready rises
    rr_en     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_hold");
    out_ready = 1'b1;
    step("bp_release");
    check("bp.first_after", 32'(out_sel), 32'd0);

    // wrap-around with sparse requests: set ptr=3 via grant on 2, then 0,2,0
    in_valid = 4'b0100;
    step("wrap_setup");
    in_valid = 4'b0101;
    step("wrap0");
    check("wrap.g0", 32'(out_sel), 32'd0);
    step("wrap1");
    check("wrap.g2", 32'(out_sel), 32'd2);
    step("wrap2");
    check("wrap.g0b", 32'(out_sel), 32'd0);

    // idle drain: single word on channel 2, then nothing
    in_valid = 4'b0100;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h50 + i);
    step("drain_word");
    in_valid = '0;
    step("drain_idle1");
    step("drain_idle2");
    check("drain.data_held", 32'(out_data), 32'h52);

    // reset mid-stream with a pending word on channel 3
    in_valid = 4'b1111;
    step("pre_rst");
    check("pre_rst.sel3", 32'(out_sel), 32'd3);
    reset = 1'b1;
    #1;
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.out_data",  32'(out_data),  32'd0);
    check("async_rst.out_sel",   32'(out_sel),   32'd0);
    check("async_rst.in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step("post_rst");
    check("post_rst.ch0", 32'(out_sel), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rr_en     = ($urandom_range(0, 4) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
